// File: rtl/spi_arbiter_if.sv
// Request/grant and SPI-controller bundle shared by the arbiter and its users.
// Latency: none, wires only.
// Backpressure: req is a level that stays high until gnt pulses.
interface spi_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int SELW = 2
);
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ*SELW-1:0] req_sel;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [DW-1:0]        rdata;
    logic                 busy;
    logic                 spi_start;
    logic [DW-1:0]        spi_data;
    logic [SELW-1:0]      spi_sel;
    logic [DW-1:0]        spi_rdata;

    // arbiter side
    modport slave (
        input  req, req_data, req_sel, spi_rdata,
        output gnt, done, rdata, busy, spi_start, spi_data, spi_sel
    );

    // requester / controller side
    modport master (
        output req, req_data, req_sel, spi_rdata,
        input  gnt, done, rdata, busy, spi_start, spi_data, spi_sel
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI controller among NREQ requesters.
// Latency: gnt 1 cycle after req seen in IDLE; done 2+XFER_CYC-1 cycles after gnt.
// Backpressure: one transaction in flight; requests wait (level held) until IDLE.
module spi_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 16,
    parameter int SELW     = 2,
    parameter int XFER_CYC = 46,
    parameter int GAP_CYC  = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_arbiter_if.slave bus
);
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (XFER_CYC > GAP_CYC) ? XFER_CYC : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CAPT  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]      state;
    logic [NREQ-1:0] req_q;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   win;
    logic            win_vld;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   spi_data_r;
    logic [SELW-1:0] spi_sel_r;
    logic [DW-1:0]   rdata_r;

    // Round-robin search over the request vector latched on entry to LOAD,
    // starting at ptr and wrapping from NREQ-1 back to 0.
    always_comb begin
        logic [IW-1:0] k;
        win     = '0;
        win_vld = 1'b0;
        k       = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = IW'((int'(ptr) + i) % NREQ);
            if (!win_vld && req_q[k]) begin
                win_vld = 1'b1;
                win     = k;
            end
        end
    end

    // Transaction sequencer: arbitrate, launch, wait out the transfer, capture, idle gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            req_q      <= '0;
            ptr        <= '0;
            idx        <= '0;
            cnt        <= '0;
            spi_data_r <= '0;
            spi_sel_r  <= '0;
            rdata_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        req_q <= bus.req;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (win_vld) begin
                        spi_data_r <= bus.req_data[int'(win)*DW +: DW];
                        spi_sel_r  <= bus.req_sel[int'(win)*SELW +: SELW];
                        idx        <= win;
                        ptr        <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
                        cnt        <= '0;
                        state      <= S_START;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_START: begin
                    // two cycles of spi_start so the controller's delayed-edge detector fires
                    if (cnt == CW'(1)) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    // the counter reaches XFER_CYC-2 on the edge into CAPT; spi_rdata is
                    // sampled on that same edge so rdata is already valid while done pulses
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(XFER_CYC - 3)) begin
                        rdata_r <= bus.spi_rdata;
                        state   <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    cnt   <= '0;
                    state <= S_GAP;
                end
                S_GAP: begin
                    if (cnt == CW'(GAP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt       = (state == S_LOAD && win_vld) ? (NREQ'(1) << win) : '0;
    assign bus.done      = (state == S_CAPT) ? (NREQ'(1) << idx) : '0;
    assign bus.busy      = (state != S_IDLE);
    assign bus.spi_start = (state == S_START);
    assign bus.spi_data  = spi_data_r;
    assign bus.spi_sel   = spi_sel_r;
    assign bus.rdata     = rdata_r;
endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: directed scenarios plus random traffic against a
// transaction-timeline model (each grant fixes its whole future by cycle offset).
// The SPI controller is modelled as returning ~data ^ sel only on the capture cycle.
module tb_spi_arbiter;
    localparam int NREQ     = 4;
    localparam int DW       = 16;
    localparam int SELW     = 2;
    localparam int XFER_CYC = 46;
    localparam int GAP_CYC  = 2;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    spi_arbiter_if #(.NREQ(NREQ), .DW(DW), .SELW(SELW)) bus ();

    spi_arbiter #(
        .NREQ(NREQ), .DW(DW), .SELW(SELW), .XFER_CYC(XFER_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] reply(input logic [DW-1:0] d, input logic [SELW-1:0] s);
        return ~d ^ DW'(s);
    endfunction

    // ---------------- behavioural model ----------------
    bit              txn;
    int              g;
    int              w;
    int              m_ptr;
    logic [DW-1:0]   m_data;
    logic [SELW-1:0] m_sel;
    logic [DW-1:0]   m_rdata;

    always @(negedge clk) begin
        int              o;
        bit              idle;
        logic [NREQ-1:0] e_gnt;
        logic [NREQ-1:0] e_done;
        if (rst) begin
            txn     = 0;
            m_ptr   = 0;
            m_data  = '0;
            m_sel   = '0;
            m_rdata = '0;
            chk("rst_gnt", bus.gnt, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_start", bus.spi_start, 0);
            chk("rst_data", bus.spi_data, 0);
            chk("rst_sel", bus.spi_sel, 0);
            chk("rst_rdata", bus.rdata, 0);
            bus.spi_rdata = DW'($urandom);
        end else begin
            o    = txn ? (cyc - g) : -1;
            idle = !txn || (o >= 2 + XFER_CYC + GAP_CYC);
            if (o == 1 + XFER_CYC) m_rdata = reply(m_data, m_sel);
            e_gnt  = (o == 0) ? (NREQ'(1) << w) : '0;
            e_done = (o == 1 + XFER_CYC) ? (NREQ'(1) << w) : '0;
            chk("m_gnt", bus.gnt, e_gnt);
            chk("m_done", bus.done, e_done);
            chk("m_busy", bus.busy, !idle);
            chk("m_start", bus.spi_start, (o == 1 || o == 2));
            chk("m_data", bus.spi_data, m_data);
            chk("m_sel", bus.spi_sel, m_sel);
            chk("m_rdata", bus.rdata, m_rdata);
            if (o == 0) begin
                m_data = bus.req_data[w*DW +: DW];
                m_sel  = bus.req_sel[w*SELW +: SELW];
            end
            bus.spi_rdata = (o == XFER_CYC) ? reply(m_data, m_sel) : DW'($urandom);
            if (idle && bus.req != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (bus.req[(m_ptr + k) % NREQ]) begin
                        w = (m_ptr + k) % NREQ;
                        break;
                    end
                end
                m_ptr = (w + 1) % NREQ;
                g     = cyc + 1;
                txn   = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input int maxc, output logic [NREQ-1:0] gv, output int n);
        gv = '0;
        n  = 0;
        for (int i = 0; i < maxc; i++) begin
            step();
            n++;
            if (bus.gnt != '0) begin
                gv = bus.gnt;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL gnt_timeout: no gnt within %0d cycles", maxc);
    endtask

    task automatic wait_done(input int maxc, output logic [NREQ-1:0] dv, output int n);
        dv = '0;
        n  = 0;
        for (int i = 0; i < maxc; i++) begin
            step();
            n++;
            if (bus.done != '0) begin
                dv = bus.done;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: no done within %0d cycles", maxc);
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (!bus.busy) return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: busy still high after %0d cycles", maxc);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [NREQ-1:0] gv;
        logic [NREQ-1:0] dv;
        logic [DW-1:0]   hold_d;
        logic [SELW-1:0] hold_s;
        int              n;
        int              n2;
        int              starts;

        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_sel  = '0;
        repeat (3) step();
        chk("reset_gnt", bus.gnt, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_spi_start", bus.spi_start, 0);
        chk("reset_spi_data", bus.spi_data, 0);
        chk("reset_rdata", bus.rdata, 0);
        rst = 1'b0;
        step();

        // single request from requester 0
        bus.req              = 4'b0001;
        bus.req_data[15:0]   = 16'hA5C3;
        bus.req_sel[1:0]     = 2'd1;
        wait_gnt(5, gv, n);
        chk("single_gnt", gv, 4'b0001);
        chk("single_gnt_latency", n, 1);
        bus.req = '0;
        starts  = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) begin
                chk("single_spi_data", bus.spi_data, 16'hA5C3);
                chk("single_spi_sel", bus.spi_sel, 2'd1);
            end
            if (bus.spi_start) starts++;
        end
        chk("single_start_cycles", starts, 2);
        wait_done(100, dv, n2);
        chk("single_done", dv, 4'b0001);
        chk("single_done_latency", n2 + 4, 47);
        chk("single_rdata", bus.rdata, 16'h5A3D);
        wait_idle(20);

        // all requesting: strict rotation from ptr 0
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_data[i*DW +: DW]     = DW'($urandom);
            bus.req_sel[i*SELW +: SELW]  = SELW'($urandom);
        end
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(200, gv, n);
            chk("rot_gnt", gv, 4'b0001 << (k % 4));
            if (k > 0) chk("rot_spacing", n, 51);
        end
        bus.req = '0;

        // request arriving during WAIT of requester 0 waits for IDLE
        repeat (5) step();
        bus.req = 4'b0100;
        wait_gnt(200, gv, n);
        chk("busy_req_gnt", gv, 4'b0100);
        chk("busy_req_delay", n + 5, 51);
        bus.req = '0;

        // reset at WAIT count 20 aborts the transfer
        repeat (23) step();
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_start", bus.spi_start, 0);
        chk("abort_data", bus.spi_data, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_rdata", bus.rdata, 0);
        step();
        step();
        rst     = 1'b0;
        bus.req = 4'b1010;
        wait_gnt(5, gv, n);
        chk("post_reset_gnt", gv, 4'b0010);
        bus.req = 4'b1000;
        wait_gnt(200, gv, n);
        chk("post_reset_gnt2", gv, 4'b1000);
        bus.req = '0;
        wait_idle(100);

        // move ptr to 3, then check wrap and stability of the latched word
        bus.req = 4'b0100;
        wait_gnt(5, gv, n);
        chk("ptr3_gnt", gv, 4'b0100);
        bus.req = '0;
        wait_idle(100);
        bus.req = 4'b1001;
        wait_gnt(5, gv, n);
        chk("wrap_gnt3", gv, 4'b1000);
        hold_d  = bus.req_data[3*DW +: DW];
        hold_s  = bus.req_sel[3*SELW +: SELW];
        bus.req = 4'b0001;
        repeat (10) step();
        bus.req_data[3*DW +: DW]    = ~hold_d;
        bus.req_sel[3*SELW +: SELW] = ~hold_s;
        repeat (5) step();
        chk("stable_spi_data", bus.spi_data, hold_d);
        chk("stable_spi_sel", bus.spi_sel, hold_s);
        wait_gnt(200, gv, n);
        chk("wrap_gnt0", gv, 4'b0001);
        bus.req = '0;
        wait_idle(100);

        // request that drops right after the IDLE->LOAD edge is still granted
        bus.req = 4'b0010;
        step();
        bus.req = '0;
        chk("drop_gnt", bus.gnt, 4'b0010);
        wait_idle(100);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            step();
            if ($urandom_range(0, 1999) == 0) begin
                rst = 1'b1;
                step();
                step();
                rst = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.gnt[i]) begin
                    if ($urandom_range(0, 3) != 0) bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(0, 29) == 0) begin
                    bus.req[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                int r;
                r = int'($urandom_range(0, NREQ - 1));
                bus.req_data[r*DW +: DW]    = DW'($urandom);
                bus.req_sel[r*SELW +: SELW] = SELW'($urandom);
            end
        end
        bus.req = '0;
        wait_idle(100);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one SPI controller.
REQ-002 Parameter DW, default 16: send and receive word width.
REQ-003 Parameter SELW, default 2: peripheral-select width.
REQ-004 Parameter XFER_CYC, default 46: clk cycles from spi_start assertion to valid spi_rdata (16+16+10+4).
REQ-005 Parameter GAP_CYC, default 2: idle cycles between transactions, with spi_start low.
REQ-006 clk  input  1  system clock; all logic is on the rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 req  input  NREQ  per-requester transaction request, level, held until gnt.
REQ-009 req_data  input  NREQ*DW  per-requester send word; slice i is [i*DW +: DW].
REQ-010 req_sel  input  NREQ*SELW  per-requester peripheral select; slice i is [i*SELW +: SELW].
REQ-011 gnt  output  NREQ  one-hot, single-cycle pulse when a request is accepted.
REQ-012 done  output  NREQ  one-hot, single-cycle pulse when rdata is valid for that requester.
REQ-013 rdata  output  DW  received word, held stable until the next done.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 spi_start  output  1  drives the SPI controller start_comm input.
REQ-016 spi_data  output  DW  drives the SPI controller data_send input.
REQ-017 spi_sel  output  SELW  drives the SPI controller CS_in input.
REQ-018 spi_rdata  input  DW  receive register from the SPI controller.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, START, WAIT, CAPT and GAP, registered and one transition per clk.
REQ-020 IDLE -> LOAD when any req bit is high; otherwise remain in IDLE.
REQ-021 In LOAD:
- select the winner by round-robin, starting the search at index ptr and wrapping NREQ-1 -> 0;
- register spi_data and spi_sel from the winner's slices;
- pulse gnt[winner];
- store the winner index;
- set ptr = winner+1 mod NREQ;
- go to START.
REQ-022 The arbiter SHALL evaluate req once per cycle in IDLE. If req drops in the same cycle as the IDLE->LOAD transition, LOAD still samples the request vector registered on that cycle; no request is granted from a zero vector, and in that case the FSM returns to IDLE with no gnt pulse.
REQ-023 START: spi_start high for exactly 2 cycles, so the controller's delayed-edge detector sees a rising edge; the cycle counter clears; then go to WAIT.
REQ-024 WAIT: spi_start low; the counter increments each cycle; go to CAPT when the counter reaches XFER_CYC-2, giving XFER_CYC cycles total from spi_start rise.
REQ-025 CAPT: register rdata from spi_rdata; pulse done[stored index]; go to GAP.
REQ-026 GAP: hold for GAP_CYC cycles, then go to IDLE. Requests pending during GAP are served from IDLE afterwards.
REQ-027 spi_data and spi_sel SHALL remain constant from LOAD through GAP, and change only in LOAD.
REQ-028 At most one transaction SHALL be in flight; requests arriving in any non-IDLE state are not granted until the FSM returns to IDLE.
REQ-029 Latency from req rising in IDLE to gnt SHALL be 1 cycle. Latency from gnt to done SHALL be 2+XFER_CYC-1 cycles.
REQ-030 Requesters SHALL be served in strict rotation: with all req bits high, grants occur in order 0,1,2,3,0,...
REQ-031 The counter SHALL be wide enough for XFER_CYC and GAP_CYC and SHALL NOT wrap.
REQ-032 A req bit that deasserts after gnt has no effect on the in-flight transaction.

Reset
REQ-033 While rst is high, the following SHALL hold asynchronously:
- state = IDLE, ptr = 0, counter = 0;
- gnt = 0, done = 0, busy = 0, spi_start = 0;
- spi_data = 0, spi_sel = 0, rdata = 0.
REQ-034 rst asserted mid-transaction SHALL abort the transaction with no done pulse. After release, the first grant goes to the lowest-index active requester.

Verification
REQ-035 Single request: req=0001, req_data[0]=16'hA5C3, sel=1 -> gnt=0001 one cycle later; spi_data=A5C3 and spi_sel=1; spi_start high for 2 cycles; done=0001 with rdata equal to the model's reply, 47 cycles after gnt.
REQ-036 All requesting: req=1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001; consecutive gnts are 2+XFER_CYC-1+1+GAP_CYC+1 cycles apart.
REQ-037 Request during a busy transaction: req[2] rises during WAIT of requester 0 -> no gnt until after GAP; then gnt=0100.
REQ-038 Reset mid-WAIT: assert rst at count 20 -> outputs go to zero immediately, no done; after release req=1010 -> gnt=0010.
REQ-039 Pointer wrap: ptr=3 with req=1001 -> gnt=1000, then gnt=0001.
REQ-040 Stability: during WAIT, change req_data and req_sel of the granted requester -> spi_data and spi_sel stay unchanged.
